// File: rtl/vga_text_writer.sv
// ---------------------------------------------------------------------------
// vga_text_writer
//   Write-side stage for the 80x60 text-mode display. Consumes a byte stream
//   on a valid/ready handshake, keeps a text cursor and drives the framebuffer
//   write port: printable cells, backspace blanking, bulk clear-screen and
//   ESC-addressed writes into the 18-byte reserved region after the cells
//   (16 palette entries, background colour, text colour).
//
// Ports
//   clk        : system clock (framebuffer write port shares it)
//   rst        : synchronous active-high reset
//   i_data     : stream byte
//   i_valid    : i_data is valid
//   o_ready    : a byte can be accepted this cycle (low only while clearing)
//   o_we       : framebuffer write strobe, one cycle per write
//   o_addr     : framebuffer write address
//   o_wdata    : framebuffer write data
//   o_cursor_x : current column, 0..HTILES-1
//   o_cursor_y : current row, 0..VTILES-1
//   o_busy     : high while a clear-screen is in progress
// ---------------------------------------------------------------------------
module vga_text_writer #(
    parameter int          HTILES     = 80,
    parameter int          VTILES     = 60,
    parameter int          FB_CELLS   = HTILES * VTILES,
    parameter int          ADDR_W     = 13,
    parameter logic [7:0]  CLEAR_CHAR = 8'h20
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        i_data,
    input  logic              i_valid,
    output logic              o_ready,
    output logic              o_we,
    output logic [ADDR_W-1:0] o_addr,
    output logic [7:0]        o_wdata,
    output logic [6:0]        o_cursor_x,
    output logic [5:0]        o_cursor_y,
    output logic              o_busy
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ESC_IDX = 2'd1,
        ESC_VAL = 2'd2,
        CLEAR   = 2'd3
    } state_t;

    localparam logic [ADDR_W-1:0] HT_A      = ADDR_W'(HTILES);
    localparam logic [ADDR_W-1:0] CELLS_A   = ADDR_W'(FB_CELLS);
    localparam logic [6:0]        X_LAST    = 7'(HTILES - 1);
    localparam logic [5:0]        Y_LAST    = 6'(VTILES - 1);
    localparam logic [7:0]        RESV_SIZE = 8'd18;

    state_t            state;
    logic [7:0]        esc_idx;
    logic [ADDR_W-1:0] clr_addr;
    logic [ADDR_W-1:0] cur_addr;
    logic              accept;

    // Linear cell address of the cursor as it stands before this byte.
    always_comb begin
        cur_addr = ADDR_W'(o_cursor_x) + ADDR_W'(o_cursor_y) * HT_A;
        accept   = i_valid && o_ready;
    end

    // Control FSM with registered write port, cursor and handshake outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            esc_idx    <= 8'd0;
            clr_addr   <= '0;
            o_ready    <= 1'b1;
            o_we       <= 1'b0;
            o_addr     <= '0;
            o_wdata    <= 8'd0;
            o_cursor_x <= 7'd0;
            o_cursor_y <= 6'd0;
            o_busy     <= 1'b0;
        end else begin
            o_we <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        case (i_data)
                            8'h08: begin
                                if (o_cursor_x != 7'd0) begin
                                    o_cursor_x <= o_cursor_x - 7'd1;
                                    o_we       <= 1'b1;
                                    o_addr     <= cur_addr - {{(ADDR_W-1){1'b0}}, 1'b1};
                                    o_wdata    <= CLEAR_CHAR;
                                end
                            end
                            8'h0A: begin
                                o_cursor_x <= 7'd0;
                                o_cursor_y <= (o_cursor_y == Y_LAST) ? 6'd0 : o_cursor_y + 6'd1;
                            end
                            8'h0D: begin
                                o_cursor_x <= 7'd0;
                            end
                            8'h0C: begin
                                // The first clear write goes out right away so the
                                // whole sweep fits inside the busy window.
                                state    <= CLEAR;
                                o_ready  <= 1'b0;
                                o_busy   <= 1'b1;
                                o_we     <= 1'b1;
                                o_addr   <= '0;
                                o_wdata  <= CLEAR_CHAR;
                                clr_addr <= {{(ADDR_W-1){1'b0}}, 1'b1};
                            end
                            8'h1B: begin
                                state <= ESC_IDX;
                            end
                            default: begin
                                o_we    <= 1'b1;
                                o_addr  <= cur_addr;
                                o_wdata <= i_data;
                                if (o_cursor_x == X_LAST) begin
                                    o_cursor_x <= 7'd0;
                                    o_cursor_y <= (o_cursor_y == Y_LAST) ? 6'd0 : o_cursor_y + 6'd1;
                                end else begin
                                    o_cursor_x <= o_cursor_x + 7'd1;
                                end
                            end
                        endcase
                    end
                end
                ESC_IDX: begin
                    if (accept) begin
                        esc_idx <= i_data;
                        state   <= ESC_VAL;
                    end
                end
                ESC_VAL: begin
                    if (accept) begin
                        if (esc_idx < RESV_SIZE) begin
                            o_we    <= 1'b1;
                            o_addr  <= CELLS_A + ADDR_W'(esc_idx);
                            o_wdata <= i_data;
                        end
                        state <= IDLE;
                    end
                end
                CLEAR: begin
                    if (clr_addr == CELLS_A) begin
                        // Last cell write is on the port this cycle; hand back.
                        state      <= IDLE;
                        o_ready    <= 1'b1;
                        o_busy     <= 1'b0;
                        o_cursor_x <= 7'd0;
                        o_cursor_y <= 6'd0;
                    end else begin
                        o_we     <= 1'b1;
                        o_addr   <= clr_addr;
                        o_wdata  <= CLEAR_CHAR;
                        clr_addr <= clr_addr + {{(ADDR_W-1){1'b0}}, 1'b1};
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vga_text_writer.sv
// ---------------------------------------------------------------------------
// tb_vga_text_writer
//   Directed plus randomized stimulus against a behavioural model of the text
//   writer. The model tracks the cursor as integers, decodes bytes by the
//   stream rules and predicts the write port contents for the cycle after
//   each clock edge.
// ---------------------------------------------------------------------------
module tb_vga_text_writer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  i_data = 8'd0;
    logic        i_valid = 1'b0;
    logic        o_ready;
    logic        o_we;
    logic [12:0] o_addr;
    logic [7:0]  o_wdata;
    logic [6:0]  o_cursor_x;
    logic [5:0]  o_cursor_y;
    logic        o_busy;

    int n_checks = 0;
    int n_pass   = 0;

    // Model state
    int  m_x = 0, m_y = 0;
    int  m_mode = 0;          // 0 text, 1 awaiting ESC index, 2 awaiting ESC value
    int  m_esc_n = 0;
    bit  m_clearing = 1'b0;
    int  m_clr_next = 0;
    bit  e_we = 1'b0;
    int  e_addr = 0, e_wdata = 0;

    vga_text_writer dut (
        .clk        (clk),
        .rst        (rst),
        .i_data     (i_data),
        .i_valid    (i_valid),
        .o_ready    (o_ready),
        .o_we       (o_we),
        .o_addr     (o_addr),
        .o_wdata    (o_wdata),
        .o_cursor_x (o_cursor_x),
        .o_cursor_y (o_cursor_y),
        .o_busy     (o_busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at t=%0t", tag, obs, exp, $time);
    endtask

    function automatic void emit(input int addr, input int data);
        e_we    = 1'b1;
        e_addr  = addr;
        e_wdata = data;
    endfunction

    function automatic void advance();
        m_x++;
        if (m_x == 80) begin
            m_x = 0;
            m_y = (m_y + 1) % 60;
        end
    endfunction

    // One clock: drive inputs, update the model on the edge, compare after it.
    task automatic step(input bit v, input int d, input bit r);
        bit accepted;
        rst     = r;
        i_valid = v;
        i_data  = 8'(d);
        @(posedge clk);
        accepted = v && !m_clearing && !r;
        e_we = 1'b0;
        if (r) begin
            m_x = 0; m_y = 0; m_mode = 0; m_clearing = 1'b0;
            e_addr = 0; e_wdata = 0;
        end else if (m_clearing) begin
            if (m_clr_next < 4800) begin
                emit(m_clr_next, 32);
                m_clr_next++;
            end else begin
                m_clearing = 1'b0;
                m_x = 0; m_y = 0;
            end
        end else if (accepted) begin
            if (m_mode == 1) begin
                m_esc_n = d;
                m_mode  = 2;
            end else if (m_mode == 2) begin
                if (m_esc_n < 18) emit(4800 + m_esc_n, d);
                m_mode = 0;
            end else if (d == 8) begin
                if (m_x > 0) begin
                    m_x--;
                    emit(m_x + 80 * m_y, 32);
                end
            end else if (d == 10) begin
                m_x = 0;
                m_y = (m_y + 1) % 60;
            end else if (d == 13) begin
                m_x = 0;
            end else if (d == 12) begin
                m_clearing = 1'b1;
                emit(0, 32);
                m_clr_next = 1;
            end else if (d == 27) begin
                m_mode = 1;
            end else begin
                emit(m_x + 80 * m_y, d);
                advance();
            end
        end
        #1;
        chk("we", int'(o_we), int'(e_we));
        if (e_we || r) begin
            chk("addr", int'(o_addr), e_addr);
            chk("wdata", int'(o_wdata), e_wdata);
        end
        chk("cursor_x", int'(o_cursor_x), m_x);
        chk("cursor_y", int'(o_cursor_y), m_y);
        chk("ready", int'(o_ready), int'(!m_clearing));
        chk("busy", int'(o_busy), int'(m_clearing));
    endtask

    function automatic int rand_byte();
        int sel;
        int b;
        sel = int'($urandom_range(0, 15));
        case (sel)
            0:       b = 8;
            1:       b = 10;
            2:       b = 13;
            3:       b = 27;
            4:       b = int'($urandom_range(0, 25));   // plausible ESC index
            default: b = int'($urandom_range(0, 255));
        endcase
        if (b == 12) b = 65;   // clears are exercised in directed tests only
        return b;
    endfunction

    initial begin
        // Reset and idle
        step(1'b0, 0, 1'b1);
        step(1'b0, 0, 1'b1);
        step(1'b0, 0, 1'b0);

        // "Hi" back to back
        step(1'b1, 8'h48, 1'b0);
        step(1'b1, 8'h69, 1'b0);
        step(1'b0, 0, 1'b0);

        // Walk to (79,59) then print 'A' at the last cell
        step(1'b1, 8'h0D, 1'b0);
        for (int i = 0; i < 59; i++) step(1'b1, 8'h0A, 1'b0);
        for (int i = 0; i < 79; i++) step(1'b1, int'($urandom_range(32, 126)), 1'b0);
        step(1'b1, 8'h41, 1'b0);

        // From (5,3): BS, CR, LF, BS at column 0
        for (int i = 0; i < 3; i++) step(1'b1, 8'h0A, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b1, int'($urandom_range(32, 126)), 1'b0);
        step(1'b1, 8'h08, 1'b0);
        step(1'b1, 8'h0D, 1'b0);
        step(1'b1, 8'h0A, 1'b0);
        step(1'b1, 8'h08, 1'b0);

        // ESC writes: index 16 lands, index 32 is dropped, 17 is last valid
        step(1'b1, 8'h1B, 1'b0); step(1'b1, 8'h10, 1'b0); step(1'b1, 8'hE0, 1'b0);
        step(1'b1, 8'h1B, 1'b0); step(1'b1, 8'h20, 1'b0); step(1'b1, 8'h55, 1'b0);
        step(1'b1, 8'h1B, 1'b0); step(1'b1, 8'h11, 1'b0); step(1'b0, 0, 1'b0);
        step(1'b1, 8'h0A, 1'b0);
        step(1'b1, 8'h1B, 1'b0); step(1'b1, 8'h12, 1'b0); step(1'b1, 8'h0D, 1'b0);

        // Clear-screen with 'Z' held behind it
        step(1'b1, 8'h0C, 1'b0);
        for (int i = 0; i < 4803; i++) step(1'b1, 8'h5A, 1'b0);
        step(1'b0, 0, 1'b0);

        // Reset after 100 clear writes
        step(1'b1, 8'h0C, 1'b0);
        for (int i = 0; i < 99; i++) step(1'b0, 0, 1'b0);
        step(1'b0, 0, 1'b1);
        for (int i = 0; i < 5; i++) step(1'b0, 0, 1'b0);

        // Reset in the middle of an escape
        step(1'b1, 8'h1B, 1'b0); step(1'b1, 8'h03, 1'b0);
        step(1'b0, 0, 1'b1);
        step(1'b1, 8'h33, 1'b0);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 3) != 0), rand_byte(), ($urandom_range(0, 299) == 0));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/vga_text_writer.md
Name: vga_text_writer

Overview:
- Upstream write-side stage for the 80x60 text-mode VGA display.
- Accepts a byte stream (ASCII plus control codes) on a valid/ready handshake and maintains a text cursor.
- Drives the framebuffer write port: one character cell per accepted printable byte, bulk clear-screen, and writes to the 18-byte reserved region after the cell array (16 palette entries, then background colour, then text colour).
- The display stage reads the same framebuffer and is unaffected by this block's timing.

Parameters:
- HTILES, 80, text columns per row.
- VTILES, 60, text rows.
- FB_CELLS, HTILES*VTILES (4800), number of character cells; the reserved region starts at this address.
- ADDR_W, 13, framebuffer address width; covers FB_CELLS+18.
- CLEAR_CHAR, 8'h20, fill byte for clear-screen and backspace.

Ports:
- clk  input  1  system clock; the framebuffer write port uses this clock.
- rst  input  1  reset.
- i_data  input  8  stream byte.
- i_valid  input  1  i_data is valid.
- o_ready  output  1  block can accept a byte this cycle.
- o_we  output  1  framebuffer write strobe, one cycle per write.
- o_addr  output  ADDR_W  framebuffer write address.
- o_wdata  output  8  framebuffer write data.
- o_cursor_x  output  7  current column, 0..HTILES-1.
- o_cursor_y  output  6  current row, 0..VTILES-1.
- o_busy  output  1  high while a clear-screen is in progress.

Behaviour:
- Clocking and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: state IDLE, cursor (0,0), o_we=0, o_addr=0, o_wdata=0, o_busy=0, o_ready=1 from the first cycle after reset.
- Reset does not touch framebuffer contents.
- Handshake:
  - A byte is accepted on any cycle where i_valid && o_ready.
  - o_ready=1 in IDLE, ESC_IDX and ESC_VAL; o_ready=0 in CLEAR.
  - Accepted bytes are never dropped.
  - Throughput is one byte per cycle outside CLEAR.
- Write timing:
  - o_we, o_addr and o_wdata are registered.
  - A write caused by a byte accepted in cycle N appears in cycle N+1 for exactly one cycle.
  - o_addr = x + HTILES*y, computed from the cursor value before that byte's update.
- States and byte decoding, with the following actions in IDLE:
  - 8'h08 (BS): if x>0, x<=x-1 and write CLEAR_CHAR at (x-1,y). If x==0, no write and no cursor change.
  - 8'h0A (LF): x<=0; y<=y+1, wrapping from VTILES-1 to 0. No write.
  - 8'h0D (CR): x<=0. No write.
  - 8'h0C (FF): go to CLEAR.
  - 8'h1B (ESC): go to ESC_IDX. No write.
  - Any other byte, including 8'h00-8'h0F (palette-coded cells) and 8'h10/8'h11 (special glyphs): write the byte at (x,y), then advance the cursor.
- Cursor advance:
  - Normally x<=x+1.
  - At x==HTILES-1: x<=0 and y<=y+1.
  - At (HTILES-1, VTILES-1) the cursor wraps to (0,0). There is no scrolling.
- ESC_IDX:
  - The accepted byte is latched as index n; go to ESC_VAL.
- ESC_VAL:
  - If n<18, write the accepted byte to address FB_CELLS+n.
  - If n>=18, discard the byte with no write.
  - Either way, return to IDLE with the cursor unchanged.
  - Control codes are not interpreted in ESC_IDX or ESC_VAL.
- CLEAR:
  - Entered the cycle after the FF byte is accepted.
  - Writes CLEAR_CHAR to addresses 0..FB_CELLS-1, one per cycle, ascending: FB_CELLS consecutive o_we pulses.
  - o_busy=1 and o_ready=0 for the whole of CLEAR.
  - After the write to FB_CELLS-1: cursor <= (0,0), return to IDLE, o_ready=1 on the following cycle.
  - The reserved region is not cleared.
- Reset mid-operation:
  - rst in CLEAR aborts immediately with no further writes.
  - rst in ESC_IDX or ESC_VAL discards the pending escape.
  - In all cases reset values apply next cycle.
- Address arithmetic is unsigned at ADDR_W bits; the maximum value is FB_CELLS+17 = 4817, with no overflow.

Test Plan:
- Reset, then stream "Hi" back-to-back -> o_we at cycles N+1 and N+2 with (addr 0, 8'h48) then (addr 1, 8'h69); cursor ends at (2,0).
- Cursor at (79,59), send 'A' -> write at addr 4799 with 8'h41; cursor becomes (0,0).
- From (5,3): send BS -> write 8'h20 at addr 244, cursor (4,3). Then CR, LF -> cursor (0,4) with no writes. Then BS at x=0 -> no write.
- Send 8'h1B, 8'h10, 8'hE0 -> single write at addr 4816 with 8'hE0; cursor unchanged. Send 8'h1B, 8'h20, 8'h55 -> no write.
- Send 8'h0C with i_valid held high and 'Z' queued behind it -> o_ready low and o_busy high; 4800 writes of 8'h20 at addrs 0..4799; then 'Z' accepted and written at addr 0.
- Assert rst after 100 clear writes -> o_we=0 next cycle, cursor (0,0), o_ready=1, no further writes.
